if_fetch_unit: RTL

- Instruction-fetch stage. Owns the PC, issues requests to instruction memory and produces the instruction and PC+4 pair that the IF/ID pipeline register latches every CLK edge.
- Drives the inputs of that register. Because the register has no enable, this block keeps its outputs constant during a stall so the register re-latches the same values.
- Handles hazard-unit stalls, branch/jump redirects and variable-latency instruction memory.

---
 rtl/if_fetch_unit.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC and feeds the IF/ID register (inst, PC+4, valid). Optional perf counters under FETCH_PERF_CNT_EN.
// Latency: 1 edge from the imem_ready cycle to out_inst.
// Backpressure: stall freezes outputs; a response that lands during a stall is parked and no new request is issued until it drains.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] out_inst,
    output logic [31:0] out_PCplus4,
    output logic        out_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall_cycles
`endif
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_HOLD   = 2'd1,
        S_SQUASH = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] squash_addr, squash_addr_nxt;
    logic [31:0] pend_inst, pend_inst_nxt;
    logic [31:0] pend_pc4, pend_pc4_nxt;
    logic        pend_vld, pend_vld_nxt;
    logic [31:0] out_inst_nxt, out_pc4_nxt;
    logic        out_valid_nxt;
    logic        bubble;

    logic [31:0] target;
    logic [31:0] pc_plus4;

    assign target   = {redirect_target[31:2], 2'b00};
    assign pc_plus4 = pc + 32'd4;

    // The request held open in SQUASH is the one abandoned by the redirect.
    assign imem_req  = !RST && (state != S_HOLD);
    assign imem_addr = (state == S_SQUASH) ? squash_addr : pc;

    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        squash_addr_nxt = squash_addr;
        pend_inst_nxt   = pend_inst;
        pend_pc4_nxt    = pend_pc4;
        pend_vld_nxt    = pend_vld;
        out_inst_nxt    = out_inst;
        out_pc4_nxt     = out_PCplus4;
        out_valid_nxt   = out_valid;
        bubble          = 1'b0;

        case (state)
            S_FETCH: begin
                if (redirect_valid) begin
                    pc_nxt = target;
                    bubble = 1'b1;
                    if (!imem_ready) begin
                        state_nxt       = S_SQUASH;
                        squash_addr_nxt = pc;
                    end
                end else if (imem_ready) begin
                    pc_nxt = pc_plus4;
                    if (stall) begin
                        pend_inst_nxt = imem_rdata;
                        pend_pc4_nxt  = pc_plus4;
                        pend_vld_nxt  = 1'b1;
                        state_nxt     = S_HOLD;
                    end else begin
                        out_inst_nxt  = imem_rdata;
                        out_pc4_nxt   = pc_plus4;
                        out_valid_nxt = 1'b1;
                    end
                end else if (!stall) begin
                    bubble = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pend_vld_nxt = 1'b0;
                    pc_nxt       = target;
                    bubble       = 1'b1;
                    state_nxt    = S_FETCH;
                end else if (!stall && pend_vld) begin
                    out_inst_nxt  = pend_inst;
                    out_pc4_nxt   = pend_pc4;
                    out_valid_nxt = 1'b1;
                    pend_vld_nxt  = 1'b0;
                    state_nxt     = S_FETCH;
                end
            end
            S_SQUASH: begin
                if (redirect_valid) begin
                    pc_nxt = target;
                    bubble = 1'b1;
                end else if (!stall) begin
                    bubble = 1'b1;
                end
                if (imem_ready) begin
                    state_nxt = S_FETCH;
                end
            end
            default: begin
                state_nxt = S_FETCH;
            end
        endcase

        if (bubble) begin
            out_inst_nxt  = NOP_INST;
            out_pc4_nxt   = 32'd0;
            out_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc          <= RESET_PC;
            squash_addr <= 32'd0;
            pend_inst   <= 32'd0;
            pend_pc4    <= 32'd0;
            pend_vld    <= 1'b0;
            out_inst    <= NOP_INST;
            out_PCplus4 <= 32'd0;
            out_valid   <= 1'b0;
        end else begin
            pc          <= pc_nxt;
            squash_addr <= squash_addr_nxt;
            pend_inst   <= pend_inst_nxt;
            pend_pc4    <= pend_pc4_nxt;
            pend_vld    <= pend_vld_nxt;
            out_inst    <= out_inst_nxt;
            out_PCplus4 <= out_pc4_nxt;
            out_valid   <= out_valid_nxt;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic delivered;

    // An instruction is delivered whenever the outputs take a new value with valid set.
    assign delivered = (redirect_valid || !stall) && out_valid_nxt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            perf_fetched      <= 32'd0;
            perf_stall_cycles <= 32'd0;
        end else begin
            if (delivered) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (stall && !redirect_valid) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule
